// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB constants and packet encodings
package usb_pkg;

    localparam int USB_BUF_DEPTH  = 64;
    localparam int USB_BUF_DATA_W = 8;
    localparam int USB_BUF_OCC_W  = 7;

    // PID selector used by USB_TX and the top-level controller
    typedef enum logic [3:0] {
        PID_NONE  = 4'd0,
        PID_DATA0 = 4'd1,
        PID_DATA1 = 4'd2,
        PID_ACK   = 4'd3,
        PID_NAK   = 4'd4,
        PID_STALL = 4'd5
    } tx_packet_t;

endpackage

// File: rtl/usb_tx_data_buffer_if.sv
// rtl/usb_tx_data_buffer_if.sv - push/pop/status bundle of the USB TX byte buffer
interface usb_tx_data_buffer_if #(
    parameter int DATA_W = usb_pkg::USB_BUF_DATA_W,
    parameter int OCC_W  = usb_pkg::USB_BUF_OCC_W
);
    logic              clear;
    logic              store_tx_data;
    logic [DATA_W-1:0] tx_data_in;
    logic              get_tx_packet_data;
    logic [DATA_W-1:0] tx_packet_data;
    logic [OCC_W-1:0]  buffer_occupancy;
    logic              full;
    logic              empty;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output clear, store_tx_data, tx_data_in, get_tx_packet_data,
        input  tx_packet_data, buffer_occupancy, full, empty, overflow_err, underflow_err
    );

    modport slave (
        input  clear, store_tx_data, tx_data_in, get_tx_packet_data,
        output tx_packet_data, buffer_occupancy, full, empty, overflow_err, underflow_err
    );
endinterface

// File: rtl/usb_tx_data_buffer.sv
// rtl/usb_tx_data_buffer.sv - first-word fall-through byte FIFO feeding USB_TX
module usb_tx_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH  = USB_BUF_DEPTH,
    parameter int DATA_W = USB_BUF_DATA_W,
    parameter int OCC_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    usb_tx_data_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              ovf_q;
    logic              udf_q;

    logic is_full;
    logic is_empty;
    logic push_ok;
    logic pop_ok;

    assign is_full  = (occ == OCC_W'(DEPTH));
    assign is_empty = (occ == '0);

    // When full, a concurrent pop frees the slot the push lands in
    assign push_ok = bus.store_tx_data && (!is_full || bus.get_tx_packet_data);
    assign pop_ok  = bus.get_tx_packet_data && !is_empty;

    always_ff @(posedge clk) begin
        if (!n_rst || bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (bus.store_tx_data && !push_ok) begin
                ovf_q <= 1'b1;
            end
            if (bus.get_tx_packet_data && is_empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (n_rst && !bus.clear && push_ok) begin
            mem[wr_ptr] <= bus.tx_data_in;
        end
    end

    assign bus.tx_packet_data   = is_empty ? '0 : mem[rd_ptr];
    assign bus.buffer_occupancy = occ;
    assign bus.full             = is_full;
    assign bus.empty            = is_empty;
    assign bus.overflow_err     = ovf_q;
    assign bus.underflow_err    = udf_q;

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// tb/tb_usb_tx_data_buffer.sv - directed self-checking bench for usb_tx_data_buffer
module tb_usb_tx_data_buffer;

    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_err;
    logic [7:0] last_head;

    usb_tx_data_buffer_if #(.DATA_W(8), .OCC_W(7)) bus ();

    usb_tx_data_buffer #(.DEPTH(64), .DATA_W(8), .OCC_W(7)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic [7:0] d, input logic gt, input logic clr);
        bus.store_tx_data      = st;
        bus.tx_data_in         = d;
        bus.get_tx_packet_data = gt;
        bus.clear              = clr;
        @(posedge clk);
        #1;
        bus.store_tx_data      = 1'b0;
        bus.tx_data_in         = 8'h00;
        bus.get_tx_packet_data = 1'b0;
        bus.clear              = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int occ, input logic [7:0] head,
                              input logic ovf, input logic udf);
        chk({tag, "_occ"},   32'(bus.buffer_occupancy), 32'(occ));
        chk({tag, "_head"},  32'(bus.tx_packet_data),   32'(head));
        chk({tag, "_full"},  32'(bus.full),             32'(occ == 64));
        chk({tag, "_empty"}, 32'(bus.empty),            32'(occ == 0));
        chk({tag, "_ovf"},   32'(bus.overflow_err),     32'(ovf));
        chk({tag, "_udf"},   32'(bus.underflow_err),    32'(udf));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.clear = 1'b0;
        bus.store_tx_data = 1'b0;
        bus.tx_data_in = 8'h00;
        bus.get_tx_packet_data = 1'b0;

        // Reset with a push strobe held: nothing may enter
        n_rst = 1'b0;
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b1, 8'h56, 1'b0, 1'b0);
        chk_status("reset", 0, 8'h00, 1'b0, 1'b0);
        n_rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk_status("post_reset", 0, 8'h00, 1'b0, 1'b0);

        // Basic push/pop ordering
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk_status("push1", 1, 8'hA5, 1'b0, 1'b0);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        chk_status("push2", 2, 8'hA5, 1'b0, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        chk_status("push3", 3, 8'hA5, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("pop1", 2, 8'h3C, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("pop2", 1, 8'hFF, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("pop3", 0, 8'h00, 1'b0, 1'b0);

        // Fill, overflow, drain through pointer wrap
        for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk_status("fill", 64, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        chk_status("overflow", 64, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            chk("drain_head", 32'(bus.tx_packet_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_status("drained", 0, 8'h00, 1'b1, 1'b0);

        // Simultaneous push/pop while full
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk_status("clear1", 0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i + 64), 1'b0, 1'b0);
        chk_status("fill2", 64, 8'h40, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk_status("full_pushpop", 64, 8'h41, 1'b0, 1'b0);
        last_head = 8'h00;
        for (int i = 0; i < 64; i++) begin
            last_head = bus.tx_packet_data;
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("last_byte", 32'(last_head), 32'h77);
        chk_status("drained2", 0, 8'h00, 1'b0, 1'b0);

        // Simultaneous push/pop while empty
        cyc(1'b1, 8'h12, 1'b1, 1'b0);
        chk_status("empty_pushpop", 1, 8'h12, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("pop_last", 0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("underflow_again", 0, 8'h00, 1'b0, 1'b1);

        // Both errors set at occupancy 10, then clear beats a push
        for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i + 8'h80), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 54; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("occ10", 10, 8'hB6, 1'b1, 1'b1);
        cyc(1'b1, 8'h5A, 1'b0, 1'b1);
        chk_status("clear_push", 0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk_status("after_clear", 0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
